// File: rtl/fabric2_mport_pkg.sv
// fabric2_mport_pkg: shared definitions for the fabric2 master port.
//   - OCP command / response codes
//   - FSM state type (ST_ERR exists only when FABRIC2_DECERR_EN is defined)
//   - default address map (port n at n<<28, top-nibble mask) and port-number width
package fabric2_mport_pkg;

  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_WR    = 3'b001;
  localparam logic [2:0] OCP_CMD_RD    = 3'b010;

  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_FAIL = 2'b10;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

  localparam int unsigned PORTNO_WIDTH_DEF = 11;
  localparam logic [31:0] PORT_MASK_DEF    = 32'hF000_0000;

  // Default base of port n: the port number placed in the top address nibble.
  function automatic logic [31:0] port_base(input int unsigned n);
    return 32'(n) << 28;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
`ifdef FABRIC2_DECERR_EN
    ,
    ST_ERR  = 2'd3
`endif
  } state_e;

endpackage

// File: rtl/fabric2_mport_if.sv
// fabric2_mport_if: one OCP request/response channel.
//   MAddr/MCmd/MData/MByteEn : request from the OCP master
//   SCmdAccept/SData/SResp    : accept and response from the OCP slave
// Modports: master (drives the request), slave (drives accept/response).
interface fabric2_mport_if;
  logic [31:0] MAddr;
  logic [2:0]  MCmd;
  logic [31:0] MData;
  logic [3:0]  MByteEn;
  logic        SCmdAccept;
  logic [31:0] SData;
  logic [1:0]  SResp;

  modport master (
    output MAddr, MCmd, MData, MByteEn,
    input  SCmdAccept, SData, SResp
  );

  modport slave (
    input  MAddr, MCmd, MData, MByteEn,
    output SCmdAccept, SData, SResp
  );
endinterface

// File: rtl/fabric2_addr_decode.sv
// fabric2_addr_decode: combinational address decoder for five ports.
//   addr   in  32            request address
//   hit    out 1             some port matched
//   portno out PORTNO_WIDTH  matching port, P0 highest priority; 0 on a miss
// Port n matches when (addr & Pn_MASK) == Pn_BASE.
module fabric2_addr_decode
  import fabric2_mport_pkg::*;
#(
  parameter int unsigned PORTNO_WIDTH = PORTNO_WIDTH_DEF,
  parameter logic [31:0] P0_BASE = port_base(0),
  parameter logic [31:0] P1_BASE = port_base(1),
  parameter logic [31:0] P2_BASE = port_base(2),
  parameter logic [31:0] P3_BASE = port_base(3),
  parameter logic [31:0] P4_BASE = port_base(4),
  parameter logic [31:0] P0_MASK = PORT_MASK_DEF,
  parameter logic [31:0] P1_MASK = PORT_MASK_DEF,
  parameter logic [31:0] P2_MASK = PORT_MASK_DEF,
  parameter logic [31:0] P3_MASK = PORT_MASK_DEF,
  parameter logic [31:0] P4_MASK = PORT_MASK_DEF
) (
  input  logic [31:0]             addr,
  output logic                    hit,
  output logic [PORTNO_WIDTH-1:0] portno
);

  always_comb begin
    hit    = 1'b1;
    portno = '0;
    if ((addr & P0_MASK) == P0_BASE)      portno = PORTNO_WIDTH'(0);
    else if ((addr & P1_MASK) == P1_BASE) portno = PORTNO_WIDTH'(1);
    else if ((addr & P2_MASK) == P2_BASE) portno = PORTNO_WIDTH'(2);
    else if ((addr & P3_MASK) == P3_BASE) portno = PORTNO_WIDTH'(3);
    else if ((addr & P4_MASK) == P4_BASE) portno = PORTNO_WIDTH'(4);
    else                                  hit    = 1'b0;
  end

endmodule

// File: rtl/fabric2_mport.sv
// fabric2_mport: single-outstanding OCP bridge from a master to the fabric.
//   clk, nrst  : clock, asynchronous active-low reset
//   mst        : OCP slave side facing the requesting master
//   fab        : OCP master side facing the fabric (registered request)
//   o_act      : pulse when a request is accepted
//   o_done     : pulse when a transaction completes
//   o_portno   : destination port (live decode in the o_act cycle, held after)
// Optional feature: FABRIC2_DECERR_EN -- unmatched addresses get a local ERR
// response instead of being routed to port 0.
module fabric2_mport
  import fabric2_mport_pkg::*;
#(
  parameter int unsigned PORTNO_WIDTH = PORTNO_WIDTH_DEF,
  parameter logic [31:0] P0_BASE = port_base(0),
  parameter logic [31:0] P1_BASE = port_base(1),
  parameter logic [31:0] P2_BASE = port_base(2),
  parameter logic [31:0] P3_BASE = port_base(3),
  parameter logic [31:0] P4_BASE = port_base(4),
  parameter logic [31:0] P0_MASK = PORT_MASK_DEF,
  parameter logic [31:0] P1_MASK = PORT_MASK_DEF,
  parameter logic [31:0] P2_MASK = PORT_MASK_DEF,
  parameter logic [31:0] P3_MASK = PORT_MASK_DEF,
  parameter logic [31:0] P4_MASK = PORT_MASK_DEF
) (
  input  logic                    clk,
  input  logic                    nrst,
  fabric2_mport_if.slave          mst,
  fabric2_mport_if.master         fab,
  output logic                    o_act,
  output logic                    o_done,
  output logic [PORTNO_WIDTH-1:0] o_portno
);

  state_e                  state, state_nxt;
  logic [2:0]              mcmd_q;
  logic [31:0]             maddr_q, mdata_q;
  logic [3:0]              mbe_q;
  logic [PORTNO_WIDTH-1:0] portno_q;

  logic                    dec_hit;
  logic [PORTNO_WIDTH-1:0] dec_portno;
  logic                    act, done, accept;
  logic [1:0]              sresp;
  logic [31:0]             sdata;

  fabric2_addr_decode #(
    .PORTNO_WIDTH (PORTNO_WIDTH),
    .P0_BASE (P0_BASE), .P1_BASE (P1_BASE), .P2_BASE (P2_BASE),
    .P3_BASE (P3_BASE), .P4_BASE (P4_BASE),
    .P0_MASK (P0_MASK), .P1_MASK (P1_MASK), .P2_MASK (P2_MASK),
    .P3_MASK (P3_MASK), .P4_MASK (P4_MASK)
  ) u_decode (
    .addr   (mst.MAddr),
    .hit    (dec_hit),
    .portno (dec_portno)
  );

  // Accept/act are combinational from IDLE; gating with nrst keeps them low
  // while reset is held even if the master is already presenting a command.
  always_comb begin
    state_nxt = state;
    act       = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    sresp     = OCP_RESP_NULL;
    sdata     = '0;
    case (state)
      ST_IDLE: begin
        if (nrst && mst.MCmd != OCP_CMD_IDLE) begin
          act    = 1'b1;
          accept = 1'b1;
`ifdef FABRIC2_DECERR_EN
          state_nxt = dec_hit ? ST_REQ : ST_ERR;
`else
          state_nxt = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (fab.SCmdAccept) begin
          // Writes are posted: completion is the accept itself.
          if (mcmd_q == OCP_CMD_WR) begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
          end else if (fab.SResp != OCP_RESP_NULL) begin
            done      = 1'b1;
            sresp     = fab.SResp;
            sdata     = fab.SData;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (fab.SResp != OCP_RESP_NULL) begin
          done      = 1'b1;
          sresp     = fab.SResp;
          sdata     = fab.SData;
          state_nxt = ST_IDLE;
        end
      end
`ifdef FABRIC2_DECERR_EN
      ST_ERR: begin
        done      = 1'b1;
        sresp     = OCP_RESP_ERR;
        state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      mcmd_q   <= OCP_CMD_IDLE;
      maddr_q  <= '0;
      mdata_q  <= '0;
      mbe_q    <= '0;
      portno_q <= '0;
    end else begin
      state <= state_nxt;
      if (act) begin
        maddr_q  <= mst.MAddr;
        mdata_q  <= mst.MData;
        mbe_q    <= mst.MByteEn;
        portno_q <= dec_hit ? dec_portno : '0;
        if (state_nxt == ST_REQ) mcmd_q <= mst.MCmd;
      end else if (state == ST_REQ && fab.SCmdAccept) begin
        mcmd_q <= OCP_CMD_IDLE;
      end
    end
  end

  assign fab.MCmd       = mcmd_q;
  assign fab.MAddr      = maddr_q;
  assign fab.MData      = mdata_q;
  assign fab.MByteEn    = mbe_q;
  assign mst.SCmdAccept = accept;
  assign mst.SResp      = sresp;
  assign mst.SData      = sdata;
  assign o_act          = act;
  assign o_done         = done;
  assign o_portno       = act ? (dec_hit ? dec_portno : '0) : portno_q;

endmodule
